// File: rtl/udp_wave_pkg.sv
// udp_wave_pkg: shared FSM encoding, default thresholds and one-hot helpers for udp_wave_router
package udp_wave_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2} state_e;
  localparam int MAX_PKT_DEF  = 1472;
  localparam int START_TH_DEF = 4096;
  localparam int STOP_TH_DEF  = 64;
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction
  function automatic logic [4:0] onehot_idx(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) if (v[i]) idx = 5'(i);
    return idx;
  endfunction
endpackage

// File: rtl/wave_play_gate.sv
// wave_play_gate: per-channel playback flag with start/stop hysteresis on FIFO fill level
module wave_play_gate
  import udp_wave_pkg::*;
#(
  parameter int CNT_W    = 13,
  parameter int START_TH = START_TH_DEF,
  parameter int STOP_TH  = STOP_TH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [CNT_W-1:0] count_i,
  output logic             play_o
);
  logic play_q, play_d;
  // clear dominates set
  always_comb play_d = (!en_i || count_i < CNT_W'(STOP_TH)) ? 1'b0 :
                       (count_i >= CNT_W'(START_TH)) ? 1'b1 : play_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) play_q <= 1'b0;
    else play_q <= play_d;
  assign play_o = play_q;
endmodule

// File: rtl/udp_wave_router.sv
// udp_wave_router: routes whole UDP payload packets to per-channel FIFOs with admission control,
// drop counting, length reporting and playback gating.
module udp_wave_router
  import udp_wave_pkg::*;
#(
  parameter int CH_NUM     = 2,
  parameter int DATA_W     = 8,
  parameter int CNT_W      = 13,
  parameter int FIFO_DEPTH = 8192,
  parameter int MAX_PKT    = MAX_PKT_DEF,
  parameter int START_TH   = START_TH_DEF,
  parameter int STOP_TH    = STOP_TH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rec_en,
  input  logic [DATA_W-1:0]       rec_data,
  input  logic                    rec_pkt_done,
  input  logic [CH_NUM-1:0]       src_id,
  input  logic [CH_NUM-1:0]       ch_en,
  input  logic [CH_NUM*CNT_W-1:0] wr_data_count,
  output logic [CH_NUM-1:0]       wr_en,
  output logic [DATA_W-1:0]       wr_data,
  output logic [CH_NUM-1:0]       play_en,
  output logic [CH_NUM*16-1:0]    pkt_len,
  output logic [CH_NUM*16-1:0]    drop_cnt,
  output logic                    err_src,
  output logic                    err_ovr
);
  localparam int CH_W = CH_NUM > 1 ? $clog2(CH_NUM) : 1;
  state_e state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d, sel_ch;
  logic [15:0] byte_cnt_q, byte_cnt_d, sel_drop;
  logic ovr_q, ovr_d, err_src_q, err_src_d, err_ovr_q, err_ovr_d, admit;
  logic [CH_NUM-1:0] wr_en_q, wr_en_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [CH_NUM*16-1:0] pkt_len_q, pkt_len_d, drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] sel_cnt;
  logic [CNT_W:0] free;
  assign sel_ch   = CH_W'(onehot_idx(32'(src_id)));
  assign sel_cnt  = wr_data_count[int'(sel_ch)*CNT_W +: CNT_W];
  assign sel_drop = drop_cnt_q[int'(sel_ch)*16 +: 16];
  // the -1 reserves room for the registered write still in flight
  assign free  = (CNT_W+1)'(FIFO_DEPTH - 1) - {1'b0, sel_cnt};
  assign admit = ch_en[sel_ch] && (free >= (CNT_W+1)'(MAX_PKT));
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    byte_cnt_d = byte_cnt_q;
    ovr_d      = ovr_q;
    wr_en_d    = '0;
    wr_data_d  = wr_data_q;
    pkt_len_d  = pkt_len_q;
    drop_cnt_d = drop_cnt_q;
    err_src_d  = 1'b0;
    err_ovr_d  = 1'b0;
    if (state_q == IDLE && rec_en) begin
      if (!is_onehot(32'(src_id))) begin
        err_src_d = 1'b1;
        state_d   = DROP;
      end else if (!admit) begin
        state_d = DROP;
        drop_cnt_d[int'(sel_ch)*16 +: 16] = sel_drop + ((sel_drop != 16'hFFFF) ? 16'd1 : 16'd0);
      end else begin
        state_d         = PASS;
        ch_d            = sel_ch;
        wr_en_d[sel_ch] = 1'b1;
        wr_data_d       = rec_data;
        byte_cnt_d      = 16'd1;
        ovr_d           = 1'b0;
      end
    end else if (state_q == PASS && rec_en) begin
      if (byte_cnt_q < 16'(MAX_PKT)) begin
        wr_en_d[ch_q] = 1'b1;
        wr_data_d     = rec_data;
        byte_cnt_d    = byte_cnt_q + 16'd1;
      end else if (!ovr_q) begin
        err_ovr_d = 1'b1;
        ovr_d     = 1'b1;
      end
    end
    // a same-cycle byte has already been folded into state_d/byte_cnt_d above
    if (rec_pkt_done && (state_q != IDLE || rec_en)) begin
      if (state_d == PASS) pkt_len_d[int'(ch_d)*16 +: 16] = byte_cnt_d;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      byte_cnt_q <= '0;
      ovr_q      <= 1'b0;
      wr_en_q    <= '0;
      wr_data_q  <= '0;
      pkt_len_q  <= '0;
      drop_cnt_q <= '0;
      err_src_q  <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      byte_cnt_q <= byte_cnt_d;
      ovr_q      <= ovr_d;
      wr_en_q    <= wr_en_d;
      wr_data_q  <= wr_data_d;
      pkt_len_q  <= pkt_len_d;
      drop_cnt_q <= drop_cnt_d;
      err_src_q  <= err_src_d;
      err_ovr_q  <= err_ovr_d;
    end
  for (genvar k = 0; k < CH_NUM; k++) begin : g_play
    wave_play_gate #(.CNT_W(CNT_W), .START_TH(START_TH), .STOP_TH(STOP_TH)) u_gate (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (ch_en[k]),
      .count_i(wr_data_count[k*CNT_W +: CNT_W]),
      .play_o (play_en[k])
    );
  end
  assign wr_en    = wr_en_q;
  assign wr_data  = wr_data_q;
  assign pkt_len  = pkt_len_q;
  assign drop_cnt = drop_cnt_q;
  assign err_src  = err_src_q;
  assign err_ovr  = err_ovr_q;
endmodule

// File: tb/tb_udp_wave_router.sv
// tb_udp_wave_router: directed self-checking bench for udp_wave_router at default parameters
module tb_udp_wave_router;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n, rec_en, rec_pkt_done, err_src, err_ovr;
  logic [7:0] rec_data, wr_data;
  logic [1:0] src_id, ch_en, wr_en, play_en;
  logic [25:0] wr_data_count;
  logic [31:0] pkt_len, drop_cnt;
  int checks = 0, failures = 0;
  int wr_cnt0 = 0, wr_cnt1 = 0, bad = 0, src_pulses = 0, ovr_pulses = 0;
  logic [8:0] exp_q[$];
  logic [8:0] e;

  udp_wave_router dut (
    .clk(clk), .rst_n(rst_n), .rec_en(rec_en), .rec_data(rec_data),
    .rec_pkt_done(rec_pkt_done), .src_id(src_id), .ch_en(ch_en),
    .wr_data_count(wr_data_count), .wr_en(wr_en), .wr_data(wr_data),
    .play_en(play_en), .pkt_len(pkt_len), .drop_cnt(drop_cnt),
    .err_src(err_src), .err_ovr(err_ovr)
  );

  always @(negedge clk) if (rst_n) begin
    if (err_src) src_pulses++;
    if (err_ovr) ovr_pulses++;
    wr_cnt0 += int'(wr_en[0]);
    wr_cnt1 += int'(wr_en[1]);
    if (wr_en != 2'b00) begin
      if (exp_q.size() == 0) bad++;
      else begin
        e = exp_q.pop_front();
        if (wr_en !== (2'b01 << e[8]) || wr_data !== e[7:0]) bad++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] src, input int n, input bit adm, input logic ch);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 1) chk("latency_wr_en", 32'(wr_en), adm ? 32'(2'b01 << ch) : 32'd0);
      rec_en = 1'b1;
      src_id = src;
      rec_data = 8'(i * 7 + n);
      rec_pkt_done = (i == n - 1);
      if (adm && i < 1472) exp_q.push_back({ch, rec_data});
    end
    @(negedge clk);
    rec_en = 1'b0;
    rec_pkt_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rec_en = 1'b0; rec_pkt_done = 1'b0; rec_data = '0;
    src_id = 2'b01; ch_en = 2'b11; wr_data_count = '0;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_play_en", 32'(play_en), 0);
    chk("rst_pkt_len", pkt_len, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_errs", 32'({err_src, err_ovr}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    send(2'b01, 100, 1'b1, 1'b0);
    chk("p100_wr_cnt0", 32'(wr_cnt0), 100);
    chk("p100_wr_cnt1", 32'(wr_cnt1), 0);
    chk("p100_pkt_len0", 32'(pkt_len[15:0]), 100);
    chk("p100_data", 32'(bad), 0);
    chk("p100_queue_empty", 32'(exp_q.size()), 0);

    wr_data_count[25:13] = 13'd7191;
    send(2'b10, 20, 1'b0, 1'b1);
    chk("full_drop_cnt1", 32'(drop_cnt[31:16]), 1);
    chk("full_drop_cnt0", 32'(drop_cnt[15:0]), 0);
    chk("full_no_write", 32'(wr_cnt1), 0);
    wr_data_count = '0;
    send(2'b10, 12, 1'b1, 1'b1);
    chk("after_drop_wr_cnt1", 32'(wr_cnt1), 12);
    chk("after_drop_pkt_len1", 32'(pkt_len[31:16]), 12);

    send(2'b11, 10, 1'b0, 1'b0);
    chk("badsrc_err_src", 32'(src_pulses), 1);
    chk("badsrc_wr_cnt0", 32'(wr_cnt0), 100);
    chk("badsrc_wr_cnt1", 32'(wr_cnt1), 12);
    chk("badsrc_drop_cnt", drop_cnt, 32'h0001_0000);

    ch_en = 2'b10;
    send(2'b01, 10, 1'b0, 1'b0);
    chk("disabled_drop_cnt0", 32'(drop_cnt[15:0]), 1);
    ch_en = 2'b11;

    send(2'b01, 1500, 1'b1, 1'b0);
    chk("ovr_wr_cnt0", 32'(wr_cnt0), 1572);
    chk("ovr_pulses", 32'(ovr_pulses), 1);
    chk("ovr_pkt_len0", 32'(pkt_len[15:0]), 1472);
    chk("ovr_data", 32'(bad), 0);
    send(2'b01, 1, 1'b1, 1'b0);
    chk("one_byte_pkt_len0", 32'(pkt_len[15:0]), 1);
    chk("one_byte_wr_cnt0", 32'(wr_cnt0), 1573);

    wr_data_count[12:0] = 13'd4095;
    repeat (2) @(negedge clk);
    chk("play_below_start", 32'(play_en), 0);
    wr_data_count[12:0] = 13'd4096;
    @(negedge clk);
    chk("play_at_start", 32'(play_en), 32'b01);
    wr_data_count[12:0] = 13'd64;
    repeat (2) @(negedge clk);
    chk("play_hold_64", 32'(play_en), 32'b01);
    wr_data_count[12:0] = 13'd63;
    @(negedge clk);
    chk("play_fall_63", 32'(play_en), 0);
    wr_data_count[12:0] = 13'd4096;
    repeat (2) @(negedge clk);
    chk("play_rise_again", 32'(play_en), 32'b01);
    ch_en = 2'b10;
    @(negedge clk);
    chk("play_ch_disable", 32'(play_en), 0);
    ch_en = 2'b11;
    wr_data_count = '0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rec_en = 1'b1; src_id = 2'b10; rec_data = 8'(i + 40); rec_pkt_done = 1'b0;
      exp_q.push_back({1'b1, rec_data});
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    rec_en = 1'b0;
    #1;
    chk("midrst_wr_en", 32'(wr_en), 0);
    chk("midrst_pkt_len", pkt_len, 0);
    chk("midrst_drop_cnt", drop_cnt, 0);
    chk("midrst_outs", 32'({play_en, err_src, err_ovr, wr_data}), 0);
    chk("midrst_partial_writes", 32'(wr_cnt1), 17);
    chk("midrst_queue_empty", 32'(exp_q.size()), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(2'b10, 10, 1'b1, 1'b1);
    chk("postrst_wr_cnt1", 32'(wr_cnt1), 27);
    chk("postrst_pkt_len", pkt_len, 32'h000A_0000);
    chk("postrst_data", 32'(bad), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
